mul_div_unit: RTL and testbench

//   Multi-cycle multiply/divide unit that sits directly downstream of the ALU control decoder.
//   - Consumes the 3-bit ALU operation code. Acts only on MULT (3'b111) and DIV (3'b101).
//   - Runs a shift-add multiply or a restoring divide, one bit per clock.
//   - Holds the results in HI/LO registers.
//   - Drives busy to the pipeline stall logic while an operation is in flight.

---
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit: shift-add MULT and restoring DIV, one bit per clock, results in HI/LO.
// Optional macro MULDIV_SIGNED_EN selects two's-complement operands (magnitudes internally, sign fix at load).
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       ALU_aluOp,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_MULT = 3'b111;
    localparam logic [2:0] OP_DIV  = 3'b101;
    localparam int         CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div0_q, div0_d;

    logic               accept;
    logic               last_iter;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quot_fin, rem_fin;

    assign accept    = (state_q == S_IDLE) && start &&
                       ((ALU_aluOp == OP_MULT) || (ALU_aluOp == OP_DIV));
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // MULT: work = {partial product, remaining multiplier bits}; add then shift right.
    assign mul_sum  = {1'b0, work_q[2*WIDTH-1:WIDTH]} + (work_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, work_q[WIDTH-1:1]};

    // DIV: work = {partial remainder, dividend bits shifting out MSB first / quotient shifting in}.
    assign div_trial = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
    assign div_ge    = (div_trial >= {1'b0, opb_q});
    assign div_sub   = div_trial[WIDTH-1:0] - opb_q;
    assign div_next  = div_ge ? {div_sub, work_q[WIDTH-2:0], 1'b1}
                              : {div_trial[WIDTH-1:0], work_q[WIDTH-2:0], 1'b0};

`ifdef MULDIV_SIGNED_EN
    logic a_neg, b_neg;
    logic neg_res_q, neg_rem_q;

    assign a_neg = a[WIDTH-1];
    assign b_neg = b[WIDTH-1];
    assign a_mag = a_neg ? ('0 - a) : a;
    assign b_mag = b_neg ? ('0 - b) : b;

    // Sign correction is folded into the result-load edge.
    assign prod_fin = neg_res_q ? ('0 - mul_next) : mul_next;
    assign quot_fin = neg_res_q ? ('0 - div_next[WIDTH-1:0]) : div_next[WIDTH-1:0];
    assign rem_fin  = neg_rem_q ? ('0 - div_next[2*WIDTH-1:WIDTH]) : div_next[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
        end
    end
`else
    assign a_mag    = a;
    assign b_mag    = b;
    assign prod_fin = mul_next;
    assign quot_fin = div_next[WIDTH-1:0];
    assign rem_fin  = div_next[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        opb_d   = opb_q;
        dvd_d   = dvd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        div0_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    dvd_d = a;
                    if (ALU_aluOp == OP_MULT) begin
                        state_d = S_MUL;
                        work_d  = {{WIDTH{1'b0}}, b_mag};
                        opb_d   = a_mag;
                    end else begin
                        state_d = S_DIV;
                        work_d  = {{WIDTH{1'b0}}, a_mag};
                        opb_d   = b_mag;
                    end
                end
            end
            S_MUL: begin
                work_d = mul_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                    hi_d    = prod_fin[2*WIDTH-1:WIDTH];
                    lo_d    = prod_fin[WIDTH-1:0];
                end
            end
            S_DIV: begin
                work_d = div_next;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                    if (opb_q == '0) begin
                        lo_d   = '1;
                        hi_d   = dvd_q;
                        div0_d = 1'b1;
                    end else begin
                        lo_d = quot_fin;
                        hi_d = rem_fin;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            opb_q   <= '0;
            dvd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            opb_q   <= opb_d;
            dvd_q   <= dvd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = (state_q == S_MUL) || (state_q == S_DIV);
    assign done = (state_q == S_DONE);
    assign div0 = div0_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, HI/LO results, div0, ignored requests, async reset, back-to-back.
module tb_mul_div_unit;
    localparam int W = 32;
    localparam logic [2:0] OP_MULT = 3'b111;
    localparam logic [2:0] OP_DIV  = 3'b101;

    logic clk = 1'b0;
    logic rst_n, start, busy, done, div0;
    logic [2:0] op;
    logic [W-1:0] a, b, hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2*W:0] exp_q[$];
    logic [W-1:0] prev_hi, prev_lo;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ALU_aluOp(op),
        .a(a), .b(b), .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Bounded wait for done, sampled on negedges; lat counts edges after accept.
    task automatic wait_done(output int lat, output int busy_cnt);
        lat = 0;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < W + 8) begin
            @(negedge clk);
            lat++;
            if (!done && busy) busy_cnt++;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic ediv0);
        int lat, busy_cnt;
        logic [2*W:0] e;
        exp_q.push_back({ediv0, ehi, elo});
        @(negedge clk);
        start = 1'b1; op = o; a = va; b = vb;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs after accept; they must not matter.
        start = 1'b0; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
        wait_done(lat, busy_cnt);
        e = exp_q.pop_front();
        check({tag, " done"}, 64'(done), 64'(1));
        check({tag, " latency"}, 64'(lat), 64'(W));
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'(W));
        check({tag, " hi"}, 64'(hi), 64'(e[2*W-1:W]));
        check({tag, " lo"}, 64'(lo), 64'(e[W-1:0]));
        check({tag, " div0"}, 64'(div0), 64'(e[2*W]));
        @(negedge clk);
        check({tag, " done_one_cycle"}, 64'(done), 64'(0));
        check({tag, " div0_one_cycle"}, 64'(div0), 64'(0));
        check({tag, " hi_hold"}, 64'(hi), 64'(e[2*W-1:W]));
        prev_hi = e[2*W-1:W];
        prev_lo = e[W-1:0];
    endtask

    initial begin
        int lat, busy_cnt, n_done, n_busy;
        rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset div0", 64'(div0), 64'(0));
        check("reset hi", 64'(hi), 64'(0));
        check("reset lo", 64'(lo), 64'(0));
        rst_n = 1'b1;

`ifdef MULDIV_SIGNED_EN
        run_op("smul_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("sdiv_negdvd", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);
        run_op("sdiv_negdvs", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
        run_op("sdiv_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run_op("sdiv0_neg", OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
`else
        run_op("mul_max_x2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0);
        run_op("mul_max_max", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run_op("div_max_1", OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_op("div_max_10", OP_DIV, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 1'b0);
`endif
        run_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("div_small", OP_DIV, 32'd7, 32'd100, 32'd7, 32'd0, 1'b0);
        run_op("div0", OP_DIV, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);

        // Unsupported op while idle is ignored and results hold.
        @(negedge clk);
        start = 1'b1; op = 3'b010; a = 32'd3; b = 32'd3;
        repeat (3) @(negedge clk);
        check("badop busy", 64'(busy), 64'(0));
        check("badop done", 64'(done), 64'(0));
        check("badop lo_hold", 64'(lo), 64'(prev_lo));
        start = 1'b0;

        // MULT 9*9 with stray starts while busy: one done, busy continuous.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
        n_done = 0; n_busy = 0;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (i == 3) begin
                check("busy hi_not_cleared", 64'(hi), 64'(prev_hi));
                check("busy lo_not_cleared", 64'(lo), 64'(prev_lo));
            end
            if (i == 5) begin start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd2; end
            if (i == 8) op = OP_DIV;
            if (i == 10) start = 1'b0;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        check("drop done_pulses", 64'(n_done), 64'(1));
        check("drop busy_cycles", 64'(n_busy), 64'(W));
        check("drop hi", 64'(hi), 64'(0));
        check("drop lo", 64'(lo), 64'(81));

        // Async reset at iteration 10 of a DIV.
        @(negedge clk);
        start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst busy", 64'(busy), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        check("rst busy", 64'(busy), 64'(0));
        check("rst done", 64'(done), 64'(0));
        check("rst div0", 64'(div0), 64'(0));
        check("rst hi", 64'(hi), 64'(0));
        check("rst lo", 64'(lo), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_mul", OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; a = 32'd6; b = 32'd7;
        @(posedge clk);
        @(negedge clk);
        wait_done(lat, busy_cnt);
        check("b2b first done", 64'(done), 64'(1));
        check("b2b first lo", 64'(lo), 64'(42));
        check("b2b first hi", 64'(hi), 64'(0));
        a = 32'h0001_0000; b = 32'h0001_0000;
        @(negedge clk);
        check("b2b done_low", 64'(done), 64'(0));
        @(negedge clk);
        check("b2b reaccept busy", 64'(busy), 64'(1));
        start = 1'b0;
        wait_done(lat, busy_cnt);
        check("b2b second done", 64'(done), 64'(1));
        check("b2b second hi", 64'(hi), 64'(1));
        check("b2b second lo", 64'(lo), 64'(0));
        check("b2b second div0", 64'(div0), 64'(0));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
